sy_tlb_v2: RTL and testbench

- Next-generation SV39 fully-associative TLB for the sy_mmu ITLB/DTLB slots.
- Adds four behaviours:
  - registered (1-cycle) lookup path for timing;
  - global-page (PTE.G) aware matching and flush;
  - full sfence.vma flush semantics (all / by ASID / by vaddr / by both);
  - invalid-first replacement with selectable PLRU or round-robin victim choice, plus duplicate-tag overwrite so multi-hit cannot occur.

---
 rtl/sy_tlb_v2.sv | 205 ++++++++++++++++++++
 tb/tb_sy_tlb_v2.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sy_tlb_v2.sv
// sy_tlb_v2: SV39 fully-associative TLB with a registered (1-cycle) lookup path.
// Lookup results are registered; global pages ignore the ASID; sfence.vma can
// flush everything, by ASID, by address or by both. A fill first reuses an
// entry with the same tag, then the lowest invalid entry, then a PLRU or
// round-robin victim.
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   flush_*                       sfence.vma request and its ASID/vaddr qualifiers
//   update_*                      fill request: VPN, ASID, page size, PTE (bit 5 = G)
//   lu_access_i/lu_asid_i/lu_vaddr_i  lookup request
//   lu_*_o                        registered lookup result (one cycle later)
module sy_tlb_v2 #(
  parameter int unsigned TLB_ENTRIES = 16,
  parameter int unsigned ASID_WIDTH  = 16,
  parameter int unsigned REPL_MODE   = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  flush_use_asid_i,
  input  logic                  flush_use_vaddr_i,
  input  logic [ASID_WIDTH-1:0] flush_asid_i,
  input  logic [63:0]           flush_vaddr_i,
  input  logic                  update_valid_i,
  input  logic [26:0]           update_vpn_i,
  input  logic [ASID_WIDTH-1:0] update_asid_i,
  input  logic                  update_is_2M_i,
  input  logic                  update_is_1G_i,
  input  logic [63:0]           update_content_i,
  input  logic                  lu_access_i,
  input  logic [ASID_WIDTH-1:0] lu_asid_i,
  input  logic [63:0]           lu_vaddr_i,
  output logic                  lu_valid_o,
  output logic                  lu_hit_o,
  output logic [63:0]           lu_content_o,
  output logic                  lu_is_2M_o,
  output logic                  lu_is_1G_o
);

  localparam int unsigned IDX_W  = $clog2(TLB_ENTRIES);
  localparam int unsigned TREE_W = TLB_ENTRIES - 1;
  localparam int unsigned VPN_W  = 27;
  localparam int unsigned PTE_W  = 64;
  localparam int unsigned G_BIT  = 5;

  // Page compare honouring the page size of the stored (or fill) tag.
  function automatic logic page_match(input logic [VPN_W-1:0] tag, input logic [VPN_W-1:0] vpn,
                                      input logic is_1g, input logic is_2m);
    page_match = (tag[26:18] == vpn[26:18]) &&
                 (is_1g || ((tag[17:9] == vpn[17:9]) && (is_2m || (tag[8:0] == vpn[8:0]))));
  endfunction

  // Mark entry idx most-recent: every node on its path points away from it.
  function automatic logic [TREE_W-1:0] plru_touch(input logic [TREE_W-1:0] tree,
                                                   input logic [IDX_W-1:0] idx);
    logic [TREE_W-1:0] t;
    logic [IDX_W-1:0]  node;
    logic [IDX_W-1:0]  sh;
    t = tree;
    for (int unsigned lvl = 0; lvl < IDX_W; lvl++) begin
      node    = IDX_W'((32'd1 << lvl) - 32'd1 + (32'(idx) >> (IDX_W - lvl)));
      sh      = idx >> (IDX_W - 1 - lvl);
      t[node] = ~sh[0];
    end
    return t;
  endfunction

  logic [TLB_ENTRIES-1:0] valid_q, is_2m_q, is_1g_q;
  logic [VPN_W-1:0]       vpn_q  [TLB_ENTRIES];
  logic [ASID_WIDTH-1:0]  asid_q [TLB_ENTRIES];
  logic [PTE_W-1:0]       pte_q  [TLB_ENTRIES];
  logic [TREE_W-1:0]      plru_q, plru_n_c;
  logic [IDX_W-1:0]       rr_q;

  logic [VPN_W-1:0]       lu_vpn_c, flush_vpn_c;
  logic [TLB_ENTRIES-1:0] lu_match_c, dup_c, flush_hit_c;
  logic [PTE_W-1:0]       hit_pte_c;
  logic                   hit_2m_c, hit_1g_c;
  logic [IDX_W-1:0]       hit_idx_c, dup_idx_c, inv_idx_c, plru_idx_c, fill_idx_c;
  logic                   use_repl_c;
  logic                   unused_vaddr_bits;

  assign lu_vpn_c    = lu_vaddr_i[38:12];
  assign flush_vpn_c = flush_vaddr_i[38:12];
  assign unused_vaddr_bits = ^{lu_vaddr_i[63:39], lu_vaddr_i[11:0],
                               flush_vaddr_i[63:39], flush_vaddr_i[11:0]};

  // Per-entry lookup match, duplicate-tag detect for fills, and flush select.
  always_comb begin : match_logic
    lu_match_c  = '0;
    dup_c       = '0;
    flush_hit_c = '0;
    for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
      lu_match_c[i] = valid_q[i] && (pte_q[i][G_BIT] || (asid_q[i] == lu_asid_i)) &&
                      page_match(vpn_q[i], lu_vpn_c, is_1g_q[i], is_2m_q[i]);
      dup_c[i]      = valid_q[i] && (asid_q[i] == update_asid_i) &&
                      (is_1g_q[i] == update_is_1G_i) && (is_2m_q[i] == update_is_2M_i) &&
                      page_match(vpn_q[i], update_vpn_i, update_is_1G_i, update_is_2M_i);
      case ({flush_use_asid_i, flush_use_vaddr_i})
        2'b00:   flush_hit_c[i] = 1'b1;
        2'b10:   flush_hit_c[i] = !pte_q[i][G_BIT] && (asid_q[i] == flush_asid_i);
        2'b01:   flush_hit_c[i] = page_match(vpn_q[i], flush_vpn_c, is_1g_q[i], is_2m_q[i]);
        default: flush_hit_c[i] = !pte_q[i][G_BIT] && (asid_q[i] == flush_asid_i) &&
                                  page_match(vpn_q[i], flush_vpn_c, is_1g_q[i], is_2m_q[i]);
      endcase
    end
  end

  // OR-mux of the matching entry; at most one entry can match.
  always_comb begin : hit_mux
    hit_pte_c = '0;
    hit_2m_c  = 1'b0;
    hit_1g_c  = 1'b0;
    hit_idx_c = '0;
    for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
      if (lu_match_c[i]) begin
        hit_pte_c = hit_pte_c | pte_q[i];
        hit_2m_c  = hit_2m_c | is_2m_q[i];
        hit_1g_c  = hit_1g_c | is_1g_q[i];
        hit_idx_c = IDX_W'(i);
      end
    end
  end

  // Fill victim: duplicate tag, else lowest invalid, else PLRU / round-robin.
  always_comb begin : victim_sel
    logic             en;
    logic [IDX_W-1:0] hi, node, sh;
    logic [TREE_W-1:0] tsh;
    en = 1'b0;
    hi = '0;
    node = '0;
    sh = '0;
    tsh = '0;
    dup_idx_c  = '0;
    inv_idx_c  = '0;
    plru_idx_c = '0;
    for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
      if (dup_c[i]) dup_idx_c = IDX_W'(i);
    end
    for (int i = int'(TLB_ENTRIES) - 1; i >= 0; i--) begin
      if (!valid_q[i]) inv_idx_c = IDX_W'(i);
    end
    // Entry i is the PLRU victim when every node on its path points towards it.
    for (int unsigned i = 0; i < TLB_ENTRIES; i++) begin
      hi = IDX_W'(i);
      en = 1'b1;
      for (int unsigned lvl = 0; lvl < IDX_W; lvl++) begin
        node = IDX_W'((32'd1 << lvl) - 32'd1 + (32'(hi) >> (IDX_W - lvl)));
        sh   = hi >> (IDX_W - 1 - lvl);
        tsh  = plru_q >> node;
        en   = en & (sh[0] ? tsh[0] : ~tsh[0]);
      end
      if (en) plru_idx_c = hi;
    end
    use_repl_c = !(|dup_c) && (&valid_q);
    if (|dup_c)          fill_idx_c = dup_idx_c;
    else if (!(&valid_q)) fill_idx_c = inv_idx_c;
    else                 fill_idx_c = (REPL_MODE == 1) ? rr_q : plru_idx_c;
  end

  // Tree update: lookup hit first, then the fill so the fill's path wins.
  always_comb begin : plru_next
    plru_n_c = plru_q;
    if (lu_access_i && (|lu_match_c)) plru_n_c = plru_touch(plru_n_c, hit_idx_c);
    if (update_valid_i && !flush_i)   plru_n_c = plru_touch(plru_n_c, fill_idx_c);
  end

  always_ff @(posedge clk_i) begin : state_update
    if (rst_i) begin
      valid_q      <= '0;
      plru_q       <= '0;
      rr_q         <= '0;
      lu_valid_o   <= 1'b0;
      lu_hit_o     <= 1'b0;
      lu_content_o <= '0;
      lu_is_2M_o   <= 1'b0;
      lu_is_1G_o   <= 1'b0;
    end else begin
      lu_valid_o   <= lu_access_i;
      lu_hit_o     <= lu_access_i && (|lu_match_c);
      lu_content_o <= lu_access_i ? hit_pte_c : '0;
      lu_is_2M_o   <= lu_access_i && hit_2m_c;
      lu_is_1G_o   <= lu_access_i && hit_1g_c;
      plru_q       <= plru_n_c;
      if (flush_i) begin
        valid_q <= valid_q & ~flush_hit_c;
      end else if (update_valid_i) begin
        valid_q[fill_idx_c] <= 1'b1;
        is_2m_q[fill_idx_c] <= update_is_2M_i;
        is_1g_q[fill_idx_c] <= update_is_1G_i;
        vpn_q[fill_idx_c]   <= update_vpn_i;
        asid_q[fill_idx_c]  <= update_asid_i;
        pte_q[fill_idx_c]   <= update_content_i;
        if (use_repl_c) rr_q <= rr_q + IDX_W'(1);
      end
    end
  end

  lu_onehot_a: assert property (@(posedge clk_i) disable iff (rst_i)
    lu_access_i |-> $onehot0(lu_match_c));
  fill_onehot_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (update_valid_i && !flush_i) |-> $onehot0(dup_c));

endmodule

// File: tb/tb_sy_tlb_v2.sv
// tb_sy_tlb_v2: drives a PLRU instance and a round-robin instance of sy_tlb_v2
// with shared stimulus and compares both against a behavioural TLB model.
module tb_sy_tlb_v2;

  localparam int N   = 16;
  localparam int LOG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, f_ua, f_uv, up_v, up_2m, up_1g, lu_acc;
  logic [15:0] f_asid, up_asid, lu_asid;
  logic [63:0] f_vaddr, up_cont, lu_vaddr;
  logic [26:0] up_vpn;

  logic        lu_valid [2];
  logic        lu_hit   [2];
  logic        lu_2m    [2];
  logic        lu_1g    [2];
  logic [63:0] lu_cont  [2];

  sy_tlb_v2 #(.TLB_ENTRIES(16), .ASID_WIDTH(16), .REPL_MODE(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_use_asid_i(f_ua),
    .flush_use_vaddr_i(f_uv), .flush_asid_i(f_asid), .flush_vaddr_i(f_vaddr),
    .update_valid_i(up_v), .update_vpn_i(up_vpn), .update_asid_i(up_asid),
    .update_is_2M_i(up_2m), .update_is_1G_i(up_1g), .update_content_i(up_cont),
    .lu_access_i(lu_acc), .lu_asid_i(lu_asid), .lu_vaddr_i(lu_vaddr),
    .lu_valid_o(lu_valid[0]), .lu_hit_o(lu_hit[0]), .lu_content_o(lu_cont[0]),
    .lu_is_2M_o(lu_2m[0]), .lu_is_1G_o(lu_1g[0]));

  sy_tlb_v2 #(.TLB_ENTRIES(16), .ASID_WIDTH(16), .REPL_MODE(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .flush_use_asid_i(f_ua),
    .flush_use_vaddr_i(f_uv), .flush_asid_i(f_asid), .flush_vaddr_i(f_vaddr),
    .update_valid_i(up_v), .update_vpn_i(up_vpn), .update_asid_i(up_asid),
    .update_is_2M_i(up_2m), .update_is_1G_i(up_1g), .update_content_i(up_cont),
    .lu_access_i(lu_acc), .lu_asid_i(lu_asid), .lu_vaddr_i(lu_vaddr),
    .lu_valid_o(lu_valid[1]), .lu_hit_o(lu_hit[1]), .lu_content_o(lu_cont[1]),
    .lu_is_2M_o(lu_2m[1]), .lu_is_1G_o(lu_1g[1]));

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, one copy per replacement mode.
  bit          mv    [2][N];
  logic [26:0] mvpn  [2][N];
  logic [15:0] masid [2][N];
  bit          m2m   [2][N];
  bit          m1g   [2][N];
  logic [63:0] mcont [2][N];
  bit          mtree [2][N-1];
  int          mrr   [2];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // True when address vpn b lies inside the page tagged a of the given size.
  function automatic bit covers(input logic [26:0] a, input logic [26:0] b, input bit g1, input bit m2);
    int sh;
    sh = g1 ? 18 : (m2 ? 9 : 0);
    return (a >> sh) == (b >> sh);
  endfunction

  // Heap-ordered binary tree: node n has children 2n+1 (left) and 2n+2 (right).
  task automatic touch(input int m, input int idx);
    int n, d;
    n = 0;
    for (int lvl = 0; lvl < LOG; lvl++) begin
      d = (idx >> (LOG - 1 - lvl)) & 1;
      mtree[m][n] = (d == 0);
      n = 2 * n + 1 + d;
    end
  endtask

  function automatic int plru_victim(input int m);
    int n;
    n = 0;
    repeat (LOG) n = 2 * n + 1 + int'(mtree[m][n]);
    return n - (N - 1);
  endfunction

  task automatic set_idle();
    rst = 1'b0; flush = 1'b0; f_ua = 1'b0; f_uv = 1'b0; f_asid = '0; f_vaddr = '0;
    up_v = 1'b0; up_vpn = '0; up_asid = '0; up_2m = 1'b0; up_1g = 1'b0; up_cont = '0;
    lu_acc = 1'b0; lu_asid = '0; lu_vaddr = '0;
  endtask

  // One clock: predict outputs from pre-edge model state, advance model, compare.
  task automatic cycle();
    bit          e_v [2], e_h [2], e_2 [2], e_1 [2];
    logic [63:0] e_c [2];
    int          mi, victim;
    bit          pathc;
    for (int m = 0; m < 2; m++) begin
      mi = -1;
      for (int i = 0; i < N; i++)
        if (mv[m][i] && (mcont[m][i][5] || masid[m][i] == lu_asid) &&
            covers(mvpn[m][i], lu_vaddr[38:12], m1g[m][i], m2m[m][i]))
          mi = i;
      e_v[m] = !rst && lu_acc;
      e_h[m] = e_v[m] && (mi >= 0);
      e_c[m] = '0; e_2[m] = 1'b0; e_1[m] = 1'b0;
      if (e_h[m]) begin
        e_c[m] = mcont[m][mi]; e_2[m] = m2m[m][mi]; e_1[m] = m1g[m][mi];
      end
      if (rst) begin
        for (int i = 0; i < N; i++) mv[m][i] = 1'b0;
        for (int i = 0; i < N - 1; i++) mtree[m][i] = 1'b0;
        mrr[m] = 0;
      end else begin
        victim = -1;
        pathc  = 1'b0;
        if (up_v && !flush) begin
          for (int i = 0; i < N; i++)
            if (mv[m][i] && masid[m][i] == up_asid && m2m[m][i] == up_2m && m1g[m][i] == up_1g &&
                covers(mvpn[m][i], up_vpn, up_1g, up_2m))
              victim = i;
          if (victim < 0)
            for (int i = N - 1; i >= 0; i--) if (!mv[m][i]) victim = i;
          if (victim < 0) begin
            pathc  = 1'b1;
            victim = (m == 0) ? plru_victim(m) : mrr[m];
          end
        end
        if (lu_acc && mi >= 0) touch(m, mi);
        if (flush) begin
          for (int i = 0; i < N; i++)
            if ((!f_ua || (!mcont[m][i][5] && masid[m][i] == f_asid)) &&
                (!f_uv || covers(mvpn[m][i], f_vaddr[38:12], m1g[m][i], m2m[m][i])))
              mv[m][i] = 1'b0;
        end else if (victim >= 0) begin
          mv[m][victim] = 1'b1; mvpn[m][victim] = up_vpn; masid[m][victim] = up_asid;
          m2m[m][victim] = up_2m; m1g[m][victim] = up_1g; mcont[m][victim] = up_cont;
          touch(m, victim);
          if (pathc) mrr[m] = (mrr[m] + 1) % N;
        end
      end
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      check_val($sformatf("m%0d lu_valid", m), 64'(lu_valid[m]), 64'(e_v[m]));
      check_val($sformatf("m%0d lu_hit", m), 64'(lu_hit[m]), 64'(e_h[m]));
      check_val($sformatf("m%0d lu_content", m), lu_cont[m], e_c[m]);
      check_val($sformatf("m%0d lu_is_2M", m), 64'(lu_2m[m]), 64'(e_2[m]));
      check_val($sformatf("m%0d lu_is_1G", m), 64'(lu_1g[m]), 64'(e_1[m]));
    end
  endtask

  task automatic lookup(input logic [15:0] asid, input logic [63:0] va);
    set_idle();
    lu_acc = 1'b1; lu_asid = asid; lu_vaddr = va;
    cycle();
  endtask

  task automatic fill(input logic [26:0] vpn, input logic [15:0] asid, input bit m2, input bit g1,
                      input logic [63:0] pte);
    set_idle();
    up_v = 1'b1; up_vpn = vpn; up_asid = asid; up_2m = m2; up_1g = g1; up_cont = pte;
    cycle();
  endtask

  task automatic do_flush(input bit ua, input bit uv, input logic [15:0] asid, input logic [63:0] va);
    set_idle();
    flush = 1'b1; f_ua = ua; f_uv = uv; f_asid = asid; f_vaddr = va;
    cycle();
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    cycle();
    cycle();
  endtask

  // Random-phase page slots; regions never overlap so no lookup can multi-hit.
  function automatic logic [26:0] slot_vpn(input int s);
    if (s < 16)      return {9'd0, 9'd0, 9'(s)};
    else if (s < 20) return {9'd4, 9'(s - 16), 9'($urandom)};
    else             return {9'(5 + s - 20), 9'($urandom), 9'($urandom)};
  endfunction

  function automatic bit slot_g(input int s);
    return (s == 0) || (s == 5) || (s == 10) || (s == 17) || (s == 22);
  endfunction

  initial begin
    int s;
    bit g;
    set_idle();
    rst = 1'b1;
    do_reset();
    check_val("rst_valid", 64'(lu_valid[0]), 64'd0);

    // Reset in the same cycle as a lookup request drops the result.
    set_idle(); rst = 1'b1; lu_acc = 1'b1; lu_vaddr = 64'h1000;
    cycle();
    check_val("rst_drop_valid", 64'(lu_valid[0]), 64'd0);

    lookup(16'd0, 64'h1000);
    check_val("empty_valid", 64'(lu_valid[0]), 64'd1);
    check_val("empty_hit", 64'(lu_hit[0]), 64'd0);
    check_val("empty_pte", lu_cont[0], 64'd0);

    // Fill with a same-cycle lookup: not visible until the next cycle.
    set_idle();
    up_v = 1'b1; up_vpn = 27'h1; up_asid = 16'd5; up_cont = 64'h0000_0000_1234_50CF;
    lu_acc = 1'b1; lu_asid = 16'd5; lu_vaddr = 64'h1000;
    cycle();
    check_val("same_cycle_fill_hit", 64'(lu_hit[0]), 64'd0);
    lookup(16'd5, 64'h1000);
    check_val("fill_hit", 64'(lu_hit[0]), 64'd1);
    check_val("fill_pte", lu_cont[0], 64'h0000_0000_1234_50CF);
    lookup(16'd6, 64'h1000);
    check_val("asid_miss", 64'(lu_hit[0]), 64'd0);

    // Global gigapage.
    fill({9'd2, 18'd0}, 16'd3, 1'b0, 1'b1, 64'h0000_0000_ABCD_00EF);
    lookup(16'd9, 64'h8012_3000);
    check_val("g1_hit", 64'(lu_hit[0]), 64'd1);
    check_val("g1_is1G", 64'(lu_1g[0]), 64'd1);
    do_flush(1'b1, 1'b0, 16'd3, 64'd0);
    lookup(16'd9, 64'h8012_3000);
    check_val("g1_asid_flush_keeps", 64'(lu_hit[0]), 64'd1);
    do_flush(1'b0, 1'b1, 16'd0, 64'h8000_0000);
    lookup(16'd9, 64'h8012_3000);
    check_val("g1_vaddr_flush_kills", 64'(lu_hit[0]), 64'd0);

    // Duplicate tag is overwritten in place.
    fill(27'h7, 16'd5, 1'b0, 1'b0, 64'h0000_0000_0000_AA01);
    fill(27'h7, 16'd5, 1'b0, 1'b0, 64'h0000_0000_0000_BB01);
    lookup(16'd5, 64'h7000);
    check_val("dup_pte", lu_cont[0], 64'h0000_0000_0000_BB01);

    // Flush-all wins over a same-cycle fill.
    set_idle();
    flush = 1'b1; up_v = 1'b1; up_vpn = 27'h20; up_asid = 16'd5; up_cont = 64'hCC01;
    cycle();
    lookup(16'd5, 64'h20000);
    check_val("flush_all_fill", 64'(lu_hit[0]), 64'd0);
    lookup(16'd5, 64'h7000);
    check_val("flush_all_old", 64'(lu_hit[0]), 64'd0);

    // Flush by ASID.
    fill(27'h30, 16'd4, 1'b0, 1'b0, 64'h3001);
    fill(27'h31, 16'd5, 1'b0, 1'b0, 64'h3101);
    fill(27'h32, 16'd4, 1'b0, 1'b0, 64'h3201);
    do_flush(1'b1, 1'b0, 16'd4, 64'd0);
    lookup(16'd4, 64'h30000);
    check_val("asid4_a_miss", 64'(lu_hit[0]), 64'd0);
    lookup(16'd5, 64'h31000);
    check_val("asid5_hit", 64'(lu_hit[0]), 64'd1);
    lookup(16'd4, 64'h32000);
    check_val("asid4_b_miss", 64'(lu_hit[0]), 64'd0);

    // Replacement once the TLB is full.
    do_reset();
    for (int i = 0; i < N; i++) fill(27'(i), 16'd1, 1'b0, 1'b0, 64'(32'h100 * i + 1));
    begin
      int order [15] = '{14, 12, 13, 8, 9, 10, 11, 0, 1, 2, 3, 4, 5, 6, 7};
      foreach (order[k]) begin
        lookup(16'd1, 64'(order[k]) << 12);
        check_val("full_access_hit", 64'(lu_hit[0]), 64'd1);
      end
    end
    fill(27'd16, 16'd1, 1'b0, 1'b0, 64'h1601);
    lookup(16'd1, 64'hF000);
    check_val("plru_evicts_15", 64'(lu_hit[0]), 64'd0);
    check_val("rr_keeps_15", 64'(lu_hit[1]), 64'd1);
    lookup(16'd1, 64'h0000);
    check_val("plru_keeps_0", 64'(lu_hit[0]), 64'd1);
    check_val("rr_evicts_0", 64'(lu_hit[1]), 64'd0);
    fill(27'd17, 16'd1, 1'b0, 1'b0, 64'h1701);
    lookup(16'd1, 64'h1000);
    check_val("rr_evicts_1", 64'(lu_hit[1]), 64'd0);
    lookup(16'd1, 64'h2000);
    check_val("rr_keeps_2", 64'(lu_hit[1]), 64'd1);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      set_idle();
      if ($urandom_range(0, 99) < 4) begin
        flush   = 1'b1;
        f_ua    = 1'($urandom);
        f_uv    = 1'($urandom);
        s       = $urandom_range(0, 2);
        f_asid  = (s == 0) ? 16'd4 : ((s == 1) ? 16'd5 : 16'd7);
        f_vaddr = {25'($urandom), slot_vpn($urandom_range(0, 23)), 12'($urandom)};
        if (1'($urandom)) begin
          up_v = 1'b1; up_vpn = slot_vpn(3); up_asid = 16'd4; up_cont = 64'hDEAD_0001;
        end
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          s       = $urandom_range(0, 23);
          g       = slot_g(s);
          up_v    = 1'b1;
          up_vpn  = slot_vpn(s);
          up_asid = g ? 16'd7 : 16'(4 + $urandom_range(0, 1));
          up_2m   = (s >= 16) && (s < 20);
          up_1g   = (s >= 20);
          up_cont = {$urandom, $urandom};
          up_cont[5] = g;
        end
        if (1'($urandom)) begin
          s        = $urandom_range(0, 25);
          lu_acc   = 1'b1;
          lu_asid  = 16'(4 + $urandom_range(0, 3));
          if (s == 24)      lu_vaddr = {25'($urandom), 9'd9, 18'($urandom), 12'($urandom)};
          else if (s == 25) lu_vaddr = {25'($urandom), 9'd0, 9'd0, 9'd20, 12'($urandom)};
          else              lu_vaddr = {25'($urandom), slot_vpn(s), 12'($urandom)};
        end
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
